axi_master_cmd_arb: RTL
=======================

# axi_master_cmd_arb

Round-robin command arbiter that shares one `axi_master` user command port between `NUM_REQ` requesters. It latches the winning requester's read/write command and drives the master's start strobe. It holds a one-hot grant for the whole transaction so the top level can steer the write and read streams, then returns a per-requester done pulse with the response ID. The block sits between the user-side clients and the `axi_master` user interface.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ADDR_WIDTH`, 32: command address width.
- `ID_WIDTH`, 4: AXI ID width; must be ≥ clog2(`NUM_REQ`).
- `TIMEOUT_CYCLES`, 1024: watchdog limit; used only with `AXI_ARB_TIMEOUT_EN`.
- `i_axi_clk`  in  1  the single clock.
- `i_axi_rst`  in  1  reset, asynchronous, active-low.
- `i_req`  in  NUM_REQ  per-requester command request, level; held until the matching `o_done` bit.
- `i_req_wr`  in  NUM_REQ  per-requester direction: 1 = write, 0 = read.
- `i_req_addr`  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `i_req_len`  in  NUM_REQ*8  flattened AXI lengths (beats − 1).
- `i_req_en_strb`  in  NUM_REQ  per-requester byte-strobe enable.
- `o_gnt`  out  NUM_REQ  one-hot grant, held from command issue to completion.
- `o_done`  out  NUM_REQ  one-cycle completion pulse on the granted bit.
- `o_resp_id`  out  ID_WIDTH  response ID captured at completion.
- `o_id_err`  out  1  sticky flag: the response ID differed from the granted index.
- `o_timeout`  out  1  sticky watchdog flag; tied to 0 when the feature is compiled out.
- `o_start_read_stb`, `o_start_write_stb`  out  1  command strobes to the master.
- `o_id`  out  ID_WIDTH  command ID; always equals the granted requester index.
- `o_addr`  out  ADDR_WIDTH, `o_data_len`  out  8, `o_en_strb`  out  1  latched command fields.
- `i_ready`  in  1  master idle indication.
- `i_resp_id`  in  ID_WIDTH  master response ID.

## Operation
- States: `IDLE`, `ISSUE_WAIT`, `BUSY`.
- `IDLE`:
  - Arbitration happens when `i_ready`=1 and any `i_req` bit is set.
  - The search starts at index `last+1` mod `NUM_REQ`; the first set bit wins.
  - Register the grant bit, `o_id`=k, and requester k's addr/len/en_strb fields; set `last`=k.
  - Pulse `o_start_write_stb` if `i_req_wr[k]`, otherwise `o_start_read_stb`. The two strobes are never asserted together.
  - Go to `ISSUE_WAIT`.
- `ISSUE_WAIT`: when `i_ready`=0, go to `BUSY`. Strobes are already low.
- `BUSY`: when `i_ready`=1:
  - Pulse `o_done[k]` and capture `o_resp_id`=`i_resp_id`.
  - If `i_resp_id` ≠ k, set `o_id_err`.
  - Clear `o_gnt` and return to `IDLE`.
- Requests are sampled only in `IDLE`. Changes to `i_req_*` while a grant is held have no effect on the latched command.
- A requester that drops `i_req` before its grant loses its turn; no error is flagged.
- Reset pointer: `last` = `NUM_REQ`−1, so requester 0 has first priority after reset.
- Mid-operation reset: all state is cleared immediately. The master must be reset in the same domain.

## Timing
- Reset values:
  - All outputs 0: `o_gnt`, `o_done`, the strobes, `o_id`, `o_addr`, `o_data_len`, `o_en_strb`, `o_resp_id`, `o_id_err`, `o_timeout`.
  - State `IDLE`.
- Request to strobe: request seen in cycle N → strobe and `o_gnt` are registered high in cycle N+1. The strobe lasts exactly one cycle.
- Completion: `i_ready` rises in cycle M → `o_done` is high in cycle M+1 and `o_gnt` is 0 in cycle M+1.
- Earliest next grant: cycle M+2, so there is at least one dead cycle between commands.
- The command fields (`o_addr`, `o_data_len`, `o_en_strb`, `o_id`) hold their value until the next grant.

## Configuration
- `AXI_ARB_TIMEOUT_EN` defined:
  - A cycle counter clears on entry to `ISSUE_WAIT` and increments every cycle in `ISSUE_WAIT` or `BUSY`.
  - When the count reaches `TIMEOUT_CYCLES`, set sticky `o_timeout`; the counter saturates.
  - The FSM keeps waiting and the grant is not revoked.
  - `o_timeout` clears only on reset.
- `AXI_ARB_TIMEOUT_EN` undefined: no counter is built and `o_timeout` = 0.

## Test plan
- Single read:
  - Stimulus: `i_req`=4'b0001, wr=0, addr 0x1000, len 3; the master model drops ready 1 cycle after the strobe and raises it 10 cycles later.
  - Response: one `o_start_read_stb` pulse with `o_id`=0, `o_addr`=0x1000, `o_data_len`=3; `o_gnt`=0001 throughout; `o_done`=0001 one cycle after ready rises; `o_resp_id`=0.
- Round robin:
  - Stimulus: `i_req`=4'b1111 held, each requester releasing its bit after its done pulse.
  - Response: grant order 0,1,2,3; with requests re-asserted, the order continues 0,1,…; no strobe during a held grant.
- Write routing:
  - Stimulus: requester 2 asserts wr=1 with en_strb=1.
  - Response: only `o_start_write_stb` pulses; `o_id`=2; `o_en_strb`=1; `o_gnt`=0100.
- ID mismatch:
  - Stimulus: the master returns `i_resp_id`=5 for grant 1.
  - Response: `o_id_err`=1 and it stays set; `o_resp_id`=5.
- Reset mid-transaction:
  - Stimulus: assert `i_axi_rst`=0 during `BUSY`.
  - Response: all outputs go to 0 immediately (asynchronously); after release, requester 0 wins first.
- Watchdog (with `AXI_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):
  - Stimulus: ready is never re-raised.
  - Response: `o_timeout`=1 after 16 cycles; `o_gnt` is still held.

Source files
------------

// File: rtl/axi_master_cmd_arb.sv
// rtl/axi_master_cmd_arb.sv - round-robin command arbiter in front of one axi_master user port
// Optional watchdog: define AXI_ARB_TIMEOUT_EN to build the ISSUE_WAIT/BUSY cycle counter.
module axi_master_cmd_arb #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          i_axi_clk,
  input  logic                          i_axi_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*8-1:0]          i_req_len,
  input  logic [NUM_REQ-1:0]            i_req_en_strb,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_done,
  output logic [ID_WIDTH-1:0]           o_resp_id,
  output logic                          o_id_err,
  output logic                          o_timeout,
  output logic                          o_start_read_stb,
  output logic                          o_start_write_stb,
  output logic [ID_WIDTH-1:0]           o_id,
  output logic [ADDR_WIDTH-1:0]         o_addr,
  output logic [7:0]                    o_data_len,
  output logic                          o_en_strb,
  input  logic                          i_ready,
  input  logic [ID_WIDTH-1:0]           i_resp_id
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] ISSUE_WAIT = 2'd1;
  localparam logic [1:0] BUSY       = 2'd2;

  if (NUM_REQ < 2 || NUM_REQ > 16 || ID_WIDTH < IDXW || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("axi_master_cmd_arb: illegal parameter combination");
  end

  logic [1:0]            state_q, state_d;
  logic [IDXW-1:0]       last_q, last_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  rd_stb_q, rd_stb_d;
  logic                  wr_stb_q, wr_stb_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic                  en_strb_q, en_strb_d;
  logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;
  logic                  id_err_q, id_err_d;

  logic                  found;
  logic [IDXW-1:0]       win_idx;

  // Rotating priority search: candidates are visited from last+1 upward, wrapping once.
  always_comb begin
    int              cand;
    logic [IDXW-1:0] cand_idx;
    found    = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(last_q) + 1 + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDXW'(cand);
      if (!found && i_req[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rd_stb_d  = 1'b0;
    wr_stb_d  = 1'b0;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    en_strb_d = en_strb_q;
    resp_id_d = resp_id_q;
    id_err_d  = id_err_q;
    case (state_q)
      IDLE: begin
        if (i_ready && found) begin
          state_d          = ISSUE_WAIT;
          last_d           = win_idx;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          id_d             = ID_WIDTH'(win_idx);
          addr_d           = i_req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          len_d            = i_req_len[win_idx*8 +: 8];
          en_strb_d        = i_req_en_strb[win_idx];
          wr_stb_d         = i_req_wr[win_idx];
          rd_stb_d         = !i_req_wr[win_idx];
        end
      end
      ISSUE_WAIT: begin
        // The master acknowledges the strobe by dropping ready.
        if (!i_ready) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (i_ready) begin
          done_d    = gnt_q;
          resp_id_d = i_resp_id;
          if (i_resp_id != id_q) begin
            id_err_d = 1'b1;
          end
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      state_q   <= IDLE;
      last_q    <= IDXW'(NUM_REQ - 1);
      gnt_q     <= '0;
      done_q    <= '0;
      rd_stb_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      en_strb_q <= 1'b0;
      resp_id_q <= '0;
      id_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rd_stb_q  <= rd_stb_d;
      wr_stb_q  <= wr_stb_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      en_strb_q <= en_strb_d;
      resp_id_q <= resp_id_d;
      id_err_q  <= id_err_d;
    end
  end

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             timeout_q, timeout_d;

  // Held at zero while idle, so every command starts counting from zero.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    if (state_q == IDLE) begin
      to_cnt_d = '0;
    end else begin
      if (to_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
      if (to_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_gnt             = gnt_q;
  assign o_done            = done_q;
  assign o_resp_id         = resp_id_q;
  assign o_id_err          = id_err_q;
  assign o_start_read_stb  = rd_stb_q;
  assign o_start_write_stb = wr_stb_q;
  assign o_id              = id_q;
  assign o_addr            = addr_q;
  assign o_data_len        = len_q;
  assign o_en_strb         = en_strb_q;

endmodule
